// File: rtl/bg_pkg.sv
// Shared sizes, types and the column wrap helper for the background index fetch path.
package bg_pkg;

  localparam int unsigned IMG_W       = 320;
  localparam int unsigned IMG_H       = 240;
  localparam int unsigned SCALE_SHIFT = 1;
  localparam int unsigned ADDR_W      = 17;
  localparam int unsigned IDX_W       = 5;
  localparam int unsigned BG_LATENCY  = 3;
  localparam int unsigned COORD_W     = 10;
  localparam int unsigned XOFF_W      = 9;
  localparam int unsigned STEP_W      = 4;

  typedef logic [IDX_W-1:0]   pal_idx_t;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [XOFF_W-1:0]  xoff_t;

  // Operands are always below 2*IMG_W, so one conditional subtract brings them into range.
  function automatic xoff_t wrap_col(input coord_t s);
    if (s >= COORD_W'(IMG_W)) begin
      return XOFF_W'(s - COORD_W'(IMG_W));
    end
    return XOFF_W'(s);
  endfunction

endpackage

// File: rtl/bg_scroll_ctrl.sv
// Frame boundary detection on vsync falling edge and the wrapping horizontal scroll offset.
module bg_scroll_ctrl
  import bg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vs_i,
  input  logic              scroll_en_i,
  input  logic [STEP_W-1:0] scroll_step_i,
  output xoff_t             x_off_o,
  output logic              frame_tick_o
);

  logic  vs_q, vs_d;
  logic  tick_q, tick_d;
  xoff_t x_off_q, x_off_d;
  logic  boundary;

  assign boundary = vs_q & ~vs_i;

  // Step and enable are only sampled at the boundary, so mid-frame changes never tear.
  always_comb begin
    vs_d    = vs_i;
    tick_d  = boundary;
    x_off_d = x_off_q;
    if (boundary && scroll_en_i) begin
      x_off_d = wrap_col(COORD_W'(x_off_q) + COORD_W'(scroll_step_i));
    end
  end

  // Edge detector idles high so a low vsync at reset release counts as a boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q    <= 1'b1;
      tick_q  <= 1'b0;
      x_off_q <= '0;
    end else begin
      vs_q    <= vs_d;
      tick_q  <= tick_d;
      x_off_q <= x_off_d;
    end
  end

  assign x_off_o      = x_off_q;
  assign frame_tick_o = tick_q;

endmodule

// File: rtl/bg_index_fetch.sv
// Raster position to background ROM address, registered palette index and aligned sync delay lines.
module bg_index_fetch
  import bg_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  coord_t            DrawX,
  input  coord_t            DrawY,
  input  logic              active_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              scroll_en,
  input  logic [STEP_W-1:0] scroll_step,
  output logic [ADDR_W-1:0] rom_addr,
  input  pal_idx_t          rom_q,
  output pal_idx_t          index_out,
  output logic              active_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic              frame_tick
);

  localparam int unsigned AW1 = ADDR_W + 1;

  xoff_t                 x_off;
  coord_t                xs, v, s, u;
  logic [AW1-1:0]        addr_full;
  logic                  force_zero;

  logic [ADDR_W-1:0]     addr_q, addr_d;
  pal_idx_t              idx_q, idx_d;
  logic [BG_LATENCY-1:0] act_q, act_d;
  logic [BG_LATENCY-1:0] hs_q, hs_d;
  logic [BG_LATENCY-1:0] vs_q, vs_d;

  bg_scroll_ctrl u_scroll (
    .clk           (Clk),
    .rst_n         (Reset_n),
    .vs_i          (vs_in),
    .scroll_en_i   (scroll_en),
    .scroll_step_i (scroll_step),
    .x_off_o       (x_off),
    .frame_tick_o  (frame_tick)
  );

  // S1 address: scaled column shifted by the scroll offset and wrapped back into the image.
  always_comb begin
    xs         = DrawX >> SCALE_SHIFT;
    v          = DrawY >> SCALE_SHIFT;
    s          = xs + COORD_W'(x_off);
    u          = COORD_W'(wrap_col(s));
    addr_full  = AW1'(v) * AW1'(IMG_W) + AW1'(u);
    force_zero = !active_in || (xs >= COORD_W'(IMG_W)) || (v >= COORD_W'(IMG_H));
    addr_d     = force_zero ? '0 : ADDR_W'(addr_full);
  end

  // S3 index gated by active two stages back, which lines up with the ROM output.
  always_comb begin
    idx_d = act_q[BG_LATENCY-2] ? rom_q : '0;
    act_d = {act_q[BG_LATENCY-2:0], active_in};
    hs_d  = {hs_q[BG_LATENCY-2:0], hs_in};
    vs_d  = {vs_q[BG_LATENCY-2:0], vs_in};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q <= '0;
      idx_q  <= '0;
      act_q  <= '0;
      hs_q   <= '1;
      vs_q   <= '1;
    end else begin
      addr_q <= addr_d;
      idx_q  <= idx_d;
      act_q  <= act_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
    end
  end

  assign rom_addr   = addr_q;
  assign index_out  = idx_q;
  assign active_out = act_q[BG_LATENCY-1];
  assign hs_out     = hs_q[BG_LATENCY-1];
  assign vs_out     = vs_q[BG_LATENCY-1];

endmodule

// File: tb/tb_bg_index_fetch.sv
// Directed bench for bg_index_fetch with a registered ROM model and hand-computed expectations.
module tb_bg_index_fetch;
  import bg_pkg::*;

  logic              clk;
  logic              rst_n;
  coord_t            draw_x, draw_y;
  logic              active_in, hs_in, vs_in, scroll_en;
  logic [STEP_W-1:0] scroll_step;
  logic [ADDR_W-1:0] rom_addr;
  pal_idx_t          rom_q;
  pal_idx_t          index_out;
  logic              active_out, hs_out, vs_out, frame_tick;

  int n_chk  = 0;
  int n_pass = 0;
  int tick_cnt = 0;
  int c0;
  int xo;

  bg_index_fetch dut (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .DrawX       (draw_x),
    .DrawY       (draw_y),
    .active_in   (active_in),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .scroll_en   (scroll_en),
    .scroll_step (scroll_step),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .index_out   (index_out),
    .active_out  (active_out),
    .hs_out      (hs_out),
    .vs_out      (vs_out),
    .frame_tick  (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM: content is the low address bits xor 0x18 (address 962 -> 0x1A).
  always_ff @(posedge clk) rom_q <= rom_addr[4:0] ^ 5'h18;

  always_ff @(posedge clk) if (frame_tick) tick_cnt <= tick_cnt + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    vs_in = 1'b0;
    step();
    vs_in = 1'b1;
    step();
  endtask

  // Offset is observed as the address of image row 1, column 0.
  task automatic read_xoff(output int x);
    draw_x    = '0;
    draw_y    = 10'd2;
    active_in = 1'b1;
    step();
    x         = int'(rom_addr) - 320;
    active_in = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, int'(rom_addr), 0);
    chk({tag, "_idx"}, int'(index_out), 0);
    chk({tag, "_act"}, int'(active_out), 0);
    chk({tag, "_hs"}, int'(hs_out), 1);
    chk({tag, "_vs"}, int'(vs_out), 1);
    chk({tag, "_tick"}, int'(frame_tick), 0);
  endtask

  initial begin
    rst_n = 1'b0; draw_x = '0; draw_y = '0; active_in = 1'b0;
    hs_in = 1'b1; vs_in = 1'b1; scroll_en = 1'b0; scroll_step = '0;
    step(3);
    chk_reset_outputs("init_rst");
    rst_n = 1'b1;
    step(2);
    read_xoff(xo); chk("init_xoff", xo, 0);
    step(3);

    // Latency: address at t+1, index and active at t+3, nothing early at t+2.
    draw_x = 10'd4; draw_y = 10'd6; active_in = 1'b1;
    step();
    chk("lat_addr", int'(rom_addr), 962);
    active_in = 1'b0; draw_x = '0; draw_y = '0;
    step();
    chk("lat_idx_t2", int'(index_out), 0);
    chk("lat_act_t2", int'(active_out), 0);
    step();
    chk("lat_idx_t3", int'(index_out), 'h1A);
    chk("lat_act_t3", int'(active_out), 1);
    step(3);

    // Blanking and exact 3-cycle sync delay.
    draw_x = 10'd700; draw_y = 10'd10; active_in = 1'b0; hs_in = 1'b0;
    step();
    chk("blank_addr", int'(rom_addr), 0);
    chk("hs_t1", int'(hs_out), 1);
    hs_in = 1'b1;
    step();
    chk("hs_t2", int'(hs_out), 1);
    step();
    chk("hs_t3", int'(hs_out), 0);
    chk("blank_idx", int'(index_out), 0);
    step();
    chk("hs_t4", int'(hs_out), 1);
    vs_in = 1'b0;
    step();
    chk("vs_tick", int'(frame_tick), 1);
    vs_in = 1'b1;
    step();
    chk("vs_t2", int'(vs_out), 1);
    chk("vs_tick_pulse", int'(frame_tick), 0);
    step();
    chk("vs_t3", int'(vs_out), 0);
    step();
    chk("vs_t4", int'(vs_out), 1);
    draw_x = 10'd700; draw_y = 10'd0; active_in = 1'b1;
    step();
    chk("xs_oob_addr", int'(rom_addr), 0);
    draw_x = 10'd0; draw_y = 10'd480;
    step();
    chk("v_oob_addr", int'(rom_addr), 0);
    active_in = 1'b0;

    // Scroll wrap: 46 frames of step 7 -> 322 mod 320.
    scroll_en = 1'b1; scroll_step = 4'd7;
    c0 = tick_cnt;
    repeat (46) frame();
    step();
    chk("scroll_ticks", tick_cnt - c0, 46);
    read_xoff(xo); chk("scroll_xoff", xo, 2);

    // Build x_off=315, then column wrap cases.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    scroll_step = 4'd15;
    repeat (21) frame();
    read_xoff(xo); chk("xoff_315", xo, 315);
    scroll_en = 1'b0;
    draw_x = 10'd20; draw_y = 10'd0; active_in = 1'b1;
    step();
    chk("colwrap_addr", int'(rom_addr), 5);
    draw_x = 10'd639;
    step();
    chk("lastcol_addr", int'(rom_addr), 314);
    draw_x = 10'd0; draw_y = 10'd479;
    step();
    chk("lastrow_addr", int'(rom_addr), 76795);
    active_in = 1'b0;

    // Offset boundary 319 + 1 -> 0.
    scroll_en = 1'b1; scroll_step = 4'd1;
    repeat (4) frame();
    read_xoff(xo); chk("xoff_319", xo, 319);
    frame();
    read_xoff(xo); chk("xoff_wrap0", xo, 0);

    // Mid-frame step change waits for the next boundary.
    frame();
    read_xoff(xo); chk("step_pre", xo, 1);
    step(3);
    scroll_step = 4'd9;
    step(5);
    read_xoff(xo); chk("step_mid", xo, 1);
    frame();
    read_xoff(xo); chk("step_post", xo, 10);

    // vsync held low fires only once.
    scroll_step = 4'd1;
    c0 = tick_cnt;
    vs_in = 1'b0;
    step(6);
    vs_in = 1'b1;
    step(2);
    chk("hold_ticks", tick_cnt - c0, 1);
    read_xoff(xo); chk("hold_xoff", xo, 11);

    // Mid-line reset with a boundary during reset and vsync low at release.
    draw_x = 10'd100; draw_y = 10'd100; active_in = 1'b1; hs_in = 1'b0;
    step(2);
    rst_n = 1'b0; vs_in = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    step(5);
    chk_reset_outputs("held_rst");
    active_in = 1'b0; hs_in = 1'b1; scroll_en = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rel_tick", int'(frame_tick), 1);
    step();
    chk("rel_tick_once", int'(frame_tick), 0);
    vs_in = 1'b1;
    step();
    read_xoff(xo); chk("rst_xoff", xo, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
